// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from ID/EX/MEM and the
// enables, flushes and status returned by the controller.
interface pipeline_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_invalid;
  logic       ex_load;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ack;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       id_stall;
  logic       flush_if_id;
  logic       halted;
  logic       timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_invalid, ex_load, ex_rd, ex_redirect,
    output mem_req, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
    input  mem_wb_en, id_stall, flush_if_id,
    input  halted, timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_invalid, ex_load, ex_rd, ex_redirect,
    input  mem_req, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
    output mem_wb_en, id_stall, flush_if_id,
    output halted, timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: rv32 5-stage hazard/sequencing controller.
// Ports: clk, reset (sync, active-high), pif (slave side of
// pipeline_ctrl_if: hazard inputs in; enables, id_stall,
// flush_if_id, halted, timeout out). With PIPELINE_CTRL_PERF_EN
// defined, adds perf_stall/perf_flush 32-bit counters.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave pif
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_stall,
  output logic [31:0]    perf_flush
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halted_q;
  logic          timeout_q, timeout_d;
  logic          hazard;
  logic          eval_run;
  logic          pc_en, if_id_en, id_ex_en;
  logic          ex_mem_en, mem_wb_en;
  logic          id_stall, flush;

  // x0 never carries a dependence.
  assign hazard = pif.ex_load && (pif.ex_rd != 5'd0) &&
    ((pif.id_use_rs1 && pif.id_rs1 == pif.ex_rd) ||
     (pif.id_use_rs2 && pif.id_rs2 == pif.ex_rd));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    eval_run  = 1'b0;
    pc_en     = 1'b0;
    if_id_en  = 1'b0;
    id_ex_en  = 1'b0;
    ex_mem_en = 1'b0;
    mem_wb_en = 1'b0;
    id_stall  = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      S_RESET: begin
        id_stall = 1'b1;
        flush    = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (pif.mem_req && !pif.mem_ack) begin
          state_d = S_MEM_WAIT;
          cnt_d   = CW'(1);
        end else begin
          eval_run = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (pif.mem_ack) begin
          eval_run = 1'b1;
        end else begin
          // Saturate; timeout stays sticky once reached.
          if (cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == TMAX) timeout_d = 1'b1;
        end
      end
      S_HALT: begin
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        id_stall  = 1'b1;
      end
      default: state_d = S_RESET;
    endcase

    // Redirect outranks load-use: the dependent
    // instruction is flushed anyway.
    if (eval_run) begin
      state_d = S_RUN;
      priority case (1'b1)
        pif.ex_redirect: begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          id_stall  = 1'b1;
          flush     = 1'b1;
        end
        hazard: begin
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          id_stall  = 1'b1;
        end
        pif.id_invalid: begin
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          id_stall  = 1'b1;
          state_d   = S_HALT;
        end
        default: begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      halted_q  <= (state_d == S_HALT);
      timeout_q <= timeout_d;
    end
  end

  assign pif.pc_en       = pc_en;
  assign pif.if_id_en    = if_id_en;
  assign pif.id_ex_en    = id_ex_en;
  assign pif.ex_mem_en   = ex_mem_en;
  assign pif.mem_wb_en   = mem_wb_en;
  assign pif.id_stall    = id_stall;
  assign pif.flush_if_id = flush;
  assign pif.halted      = halted_q;
  assign pif.timeout     = timeout_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic redir;
  logic stall_cyc;

  assign redir = flush && (state_q != S_RESET);
  assign stall_cyc = !pc_en &&
    (state_q == S_RUN || state_q == S_MEM_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (stall_cyc) perf_stall <= perf_stall + 32'd1;
      if (redir)     perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vector table, hand sequences
// and randomized stimulus against a behavioural model.
module tb_pipeline_ctrl;

  localparam int TMO = 2;

  localparam logic [6:0] O_RST = 7'b00000_1_1;
  localparam logic [6:0] O_RUN = 7'b11111_0_0;
  localparam logic [6:0] O_FRZ = 7'b00000_0_0;
  localparam logic [6:0] O_BUB = 7'b00111_1_0;
  localparam logic [6:0] O_RED = 7'b11111_1_1;
  localparam logic [6:0] O_HLT = 7'b00011_1_0;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [4:0] rd;
    logic       u1;
    logic [4:0] r1;
    logic       u2;
    logic [4:0] r2;
    logic       red;
    logic       req;
    logic       ack;
    logic       inv;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [8:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  bit   m_rst, m_wait, m_halt, m_tmo;
  int   m_cnt;
  logic [31:0] m_pstall, m_pflush;

  pipeline_ctrl_if pif();

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush;
  pipeline_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pif(pif),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );
`else
  pipeline_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pif(pif)
  );
`endif

  always #5 clk = ~clk;

  function automatic stim_t st(
    bit rst, bit ld, int rd, bit u1, int r1, bit u2, int r2,
    bit red, bit req, bit ack, bit inv);
    stim_t s;
    s.rst = rst; s.ld = ld; s.rd = 5'(rd);
    s.u1 = u1; s.r1 = 5'(r1); s.u2 = u2; s.r2 = 5'(r2);
    s.red = red; s.req = req; s.ack = ack; s.inv = inv;
    return s;
  endfunction

  function automatic bit hz(input stim_t s);
    return s.ld && s.rd != 0 &&
      ((s.u1 && s.r1 == s.rd) || (s.u2 && s.r2 == s.rd));
  endfunction

  // {pc, if_id, id_ex, ex_mem, mem_wb, stall, flush, halted, timeout}
  function automatic logic [8:0] model_out(input stim_t s);
    logic [6:0] e;
    if (m_rst) e = O_RST;
    else if (m_halt) e = O_HLT;
    else if (m_wait && !s.ack) e = O_FRZ;
    else if (!m_wait && s.req && !s.ack) e = O_FRZ;
    else if (s.red) e = O_RED;
    else if (hz(s)) e = O_BUB;
    else if (s.inv) e = O_BUB;
    else e = O_RUN;
    return {e, m_halt, m_tmo};
  endfunction

  task automatic model_reset();
    m_rst = 1; m_wait = 0; m_halt = 0; m_tmo = 0; m_cnt = 0;
    m_pstall = 0; m_pflush = 0;
  endtask

  task automatic model_step(input stim_t s);
    logic [8:0] e;
    e = model_out(s);
    if (!m_rst && !m_halt && !e[8]) m_pstall = m_pstall + 1;
    if (!m_rst && e[2]) m_pflush = m_pflush + 1;
    if (s.rst) model_reset();
    else if (m_rst) m_rst = 0;
    else if (m_halt) m_halt = 1;
    else if (m_wait && !s.ack) begin
      if (m_cnt < TMO) m_cnt++;
      if (m_cnt >= TMO) m_tmo = 1;
    end else if (!m_wait && s.req && !s.ack) begin
      m_wait = 1;
      m_cnt = 1;
    end else begin
      m_wait = 0;
      if (!s.red && !hz(s) && s.inv) m_halt = 1;
    end
  endtask

  task automatic drive(input stim_t s);
    reset = s.rst;
    pif.ex_load = s.ld; pif.ex_rd = s.rd;
    pif.id_use_rs1 = s.u1; pif.id_rs1 = s.r1;
    pif.id_use_rs2 = s.u2; pif.id_rs2 = s.r2;
    pif.ex_redirect = s.red; pif.mem_req = s.req;
    pif.mem_ack = s.ack; pif.id_invalid = s.inv;
  endtask

  function automatic logic [8:0] got_out();
    return {pif.pc_en, pif.if_id_en, pif.id_ex_en,
            pif.ex_mem_en, pif.mem_wb_en, pif.id_stall,
            pif.flush_if_id, pif.halted, pif.timeout};
  endfunction

  task automatic apply(input stim_t s, input logic [8:0] x,
                       input bit use_model, input string nm);
    logic [8:0] e, g;
    @(negedge clk);
    drive(s);
    #1;
    e = use_model ? model_out(s) : x;
    g = got_out();
    nvec++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got %b want %b", nm, g, e);
    end
`ifdef PIPELINE_CTRL_PERF_EN
    nvec++;
    if (perf_stall !== m_pstall || perf_flush !== m_pflush) begin
      nerr++;
      $display("FAIL %s perf: got %0d/%0d want %0d/%0d", nm,
               perf_stall, perf_flush, m_pstall, m_pflush);
    end
`endif
    model_step(s);
  endtask

  function automatic stim_t rnd_stim(input bit allow_rst);
    stim_t s;
    s.rst = allow_rst && ($urandom_range(0, 39) == 0);
    s.ld  = ($urandom_range(0, 2) == 0);
    s.rd  = 5'($urandom_range(0, 3));
    s.u1  = 1'($urandom);
    s.r1  = 5'($urandom_range(0, 3));
    s.u2  = 1'($urandom);
    s.r2  = 5'($urandom_range(0, 3));
    s.red = ($urandom_range(0, 7) == 0);
    s.req = ($urandom_range(0, 2) == 0);
    s.ack = 1'($urandom);
    s.inv = ($urandom_range(0, 49) == 0);
    return s;
  endfunction

  vec_t  tbl[28];
  stim_t idle, rq, ak, rs;

  initial begin
    idle = st(0,0,0,0,0,0,0,0,0,0,0);
    rq   = st(0,0,0,0,0,0,0,0,1,0,0);
    ak   = st(0,0,0,0,0,0,0,0,1,1,0);
    rs   = st(1,0,0,0,0,0,0,0,0,0,0);

    tbl[0]  = '{rs, {O_RST, 2'b00}};
    tbl[1]  = '{idle, {O_RST, 2'b00}};
    tbl[2]  = '{idle, {O_RUN, 2'b00}};
    tbl[3]  = '{st(0,1,5,1,5,0,0,0,0,0,0), {O_BUB, 2'b00}};
    tbl[4]  = '{st(0,1,0,1,0,0,0,0,0,0,0), {O_RUN, 2'b00}};
    tbl[5]  = '{st(0,1,7,0,0,1,7,0,0,0,0), {O_BUB, 2'b00}};
    tbl[6]  = '{st(0,1,7,0,7,0,7,0,0,0,0), {O_RUN, 2'b00}};
    tbl[7]  = '{st(0,1,5,1,5,0,0,1,0,0,0), {O_RED, 2'b00}};
    tbl[8]  = '{ak, {O_RUN, 2'b00}};
    tbl[9]  = '{rq, {O_FRZ, 2'b00}};
    tbl[10] = '{rq, {O_FRZ, 2'b00}};
    tbl[11] = '{rq, {O_FRZ, 2'b01}};
    tbl[12] = '{ak, {O_RUN, 2'b01}};
    tbl[13] = '{idle, {O_RUN, 2'b01}};
    tbl[14] = '{rq, {O_FRZ, 2'b01}};
    tbl[15] = '{st(0,0,0,0,0,0,0,1,1,1,0), {O_RED, 2'b01}};
    tbl[16] = '{rq, {O_FRZ, 2'b01}};
    tbl[17] = '{st(0,1,3,0,0,1,3,0,1,1,0), {O_BUB, 2'b01}};
    tbl[18] = '{st(0,0,0,0,0,0,0,0,0,0,1), {O_BUB, 2'b01}};
    tbl[19] = '{idle, {O_HLT, 2'b11}};
    tbl[20] = '{st(0,1,2,1,2,0,0,1,1,0,0), {O_HLT, 2'b11}};
    tbl[21] = '{rs, {O_HLT, 2'b11}};
    tbl[22] = '{idle, {O_RST, 2'b00}};
    tbl[23] = '{idle, {O_RUN, 2'b00}};
    tbl[24] = '{rq, {O_FRZ, 2'b00}};
    tbl[25] = '{st(1,0,0,0,0,0,0,0,1,0,0), {O_FRZ, 2'b00}};
    tbl[26] = '{idle, {O_RST, 2'b00}};
    tbl[27] = '{idle, {O_RUN, 2'b00}};

    drive(rs);
    @(posedge clk);
    model_reset();

    for (int i = 0; i < 28; i++)
      apply(tbl[i].s, tbl[i].e, 1'b0, $sformatf("vec%0d", i));

    // Halt holds for 20 cycles, then a reset pulse recovers.
    apply(st(0,0,0,0,0,0,0,0,0,0,1), '0, 1'b1, "halt_entry");
    for (int i = 0; i < 20; i++) begin
      stim_t s;
      s = rnd_stim(1'b0);
      @(negedge clk);
      drive(s);
      #1;
      nvec++;
      if (pif.pc_en !== 1'b0 || pif.halted !== 1'b1) begin
        nerr++;
        $display("FAIL halt_hold%0d: pc_en=%b halted=%b want 0/1",
                 i, pif.pc_en, pif.halted);
      end
      model_step(s);
    end
    apply(rs, '0, 1'b1, "halt_reset");
    apply(idle, {O_RST, 2'b00}, 1'b0, "halt_rst_state");
    apply(idle, {O_RUN, 2'b00}, 1'b0, "halt_run");

    for (int i = 0; i < 1500; i++)
      apply(rnd_stim(1'b1), '0, 1'b1, $sformatf("rnd%0d", i));

`ifdef PIPELINE_CTRL_PERF_EN
    apply(rs, '0, 1'b1, "perf_rst");
    apply(idle, '0, 1'b1, "perf_i0");
    apply(idle, '0, 1'b1, "perf_i1");
    apply(st(0,1,5,1,5,0,0,0,0,0,0), '0, 1'b1, "perf_lu");
    apply(st(0,0,0,0,0,0,0,1,0,0,0), '0, 1'b1, "perf_red");
    apply(rq, '0, 1'b1, "perf_w0");
    apply(rq, '0, 1'b1, "perf_w1");
    apply(rq, '0, 1'b1, "perf_w2");
    apply(ak, '0, 1'b1, "perf_ack");
    @(negedge clk);
    drive(idle);
    #1;
    nvec++;
    if (perf_stall !== 32'd4 || perf_flush !== 32'd1) begin
      nerr++;
      $display("FAIL perf_totals: got %0d/%0d want 4/1",
               perf_stall, perf_flush);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the rv32 five-stage pipeline (IF, ID, EX, MEM, WB). It drives the pipeline-register enables and flushes, and supplies the `stall` input of the instruction decoder. It detects load-use hazards, redirects on taken branches and jumps, holds the pipeline while data memory is busy, and halts on an invalid instruction.

## Interface
- `MEM_TIMEOUT`, default 16: maximum MEM wait cycles before `timeout` is asserted. Must be ≥1.
- `clk`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `id_rs1`, `id_rs2`  in  5 each  — source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  — the ID instruction reads that source.
- `id_invalid`  in  1  — `invalid` flag from the decoder for the ID instruction.
- `ex_load`  in  1  — the EX instruction is a load (`mem_op` is one of the LOAD_* values).
- `ex_rd`  in  5  — destination register of the EX instruction.
- `ex_redirect`  in  1  — a taken branch, JAL or JALR resolved in EX.
- `mem_req`  in  1  — the MEM instruction accesses data memory.
- `mem_ack`  in  1  — data memory completed the access this cycle.
- `pc_en`  out  1  — PC update enable.
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  — pipeline-register load enables.
- `id_stall`  out  1  — to the decoder's `stall`; forces CTRL_NOP into ID/EX.
- `flush_if_id`  out  1  — clears IF/ID to a bubble.
- `halted`  out  1  — core halted on an invalid instruction.
- `timeout`  out  1  — sticky; MEM wait exceeded `MEM_TIMEOUT`.

## Operation
- State register with four states: RUN, MEM_WAIT, HALT, RESET. `reset` forces RESET. RESET always moves to RUN on the next cycle.
- **RESET:** all enables 0, `id_stall` 1, `flush_if_id` 1, `halted` 0, `timeout` 0, wait counter 0.
- **RUN, evaluated each cycle in priority order:**
  1. `mem_req && !mem_ack`: freeze. All enables 0. `id_stall` 0. Go to MEM_WAIT and set the wait counter to 1.
  2. `ex_redirect`: `pc_en`=1, `flush_if_id`=1, `id_stall`=1, all register enables 1. Two bubbles follow the branch.
  3. Load-use hazard: `ex_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))`. Then `pc_en`=0, `if_id_en`=0, `id_stall`=1, `id_ex_en`=`ex_mem_en`=`mem_wb_en`=1. This is a one-cycle bubble; the hazard clears on the next cycle because the load has left EX.
  4. `id_invalid`: `id_stall`=1 (a bubble enters EX), `pc_en`=0, `if_id_en`=0, downstream enables 1. Go to HALT.
  5. Otherwise all enables 1, `id_stall` 0, `flush_if_id` 0.
- **MEM_WAIT:** all enables 0.
  - On `mem_ack`, return to RUN. That cycle behaves as RUN with item 1 bypassed, so ack plus redirect or hazard is evaluated the same cycle.
  - Otherwise increment the wait counter. When it reaches `MEM_TIMEOUT`, set `timeout`; it holds until reset. The counter saturates and the wait continues.
- **HALT:** `halted`=1. `ex_mem_en`=`mem_wb_en`=1 so older instructions drain. `pc_en`=`if_id_en`=`id_ex_en`=0, `id_stall`=1. Exit only by `reset`.
- Register index x0 never creates a hazard.
- A redirect arriving with a load-use hazard wins; the dependent ID instruction is flushed anyway.
- Wait counter width is `$clog2(MEM_TIMEOUT+1)`.

## Timing
- State, counter, `halted` and `timeout` are registered.
- Enables, `id_stall` and `flush_if_id` are combinational from the current state and inputs. There is no extra latency, so a hazard is handled in the cycle it appears.
- Load-use costs exactly 1 bubble cycle. Redirect costs 2 bubble cycles. A MEM access with N-cycle `mem_ack` latency costs N−1 frozen cycles; `mem_ack` in the request cycle costs 0.
- `reset` asserted mid-MEM_WAIT or in HALT takes effect at the next edge. All outputs take their RESET values the cycle after.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined: adds output ports `perf_stall` (out, 32) and `perf_flush` (out, 32), both zeroed by `reset`.
  - `perf_stall` counts cycles with `pc_en`=0 outside RESET and HALT.
  - `perf_flush` counts redirect cycles.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Load-use:** `ex_load`=1, `ex_rd`=5, `id_use_rs1`=1, `id_rs1`=5 → one cycle with `pc_en`=0, `if_id_en`=0, `id_stall`=1. Repeat with `ex_rd`=0 → no stall.
- **Redirect plus hazard:** `ex_redirect`=1 in the same cycle as the load-use case above → `flush_if_id`=1, `pc_en`=1, `id_stall`=1.
- **Memory wait:** `mem_req`=1, `mem_ack` arrives 3 cycles later → enables 0 for 3 cycles, all 1 on the ack cycle. With `MEM_TIMEOUT`=2, `timeout` rises on cycle 2 and stays 1 after the ack.
- **Invalid instruction:** `id_invalid`=1 → `halted`=1 next cycle, `pc_en` stays 0 for 20 cycles; `reset` pulse → `halted`=0, RUN after RESET.
- **Reset mid-wait:** `reset` asserted in MEM_WAIT → next cycle all enables 0, `timeout`=0; RUN the following cycle.
- **Perf counters** (`PIPELINE_CTRL_PERF_EN`): 1 load-use plus 1 redirect plus a 3-cycle wait → `perf_stall`=4, `perf_flush`=1.
